// File: rtl/program_counter_unit.sv
// Program counter with a hardware return stack, call/return handling and
// halt-on-FLAGF that only a reset or a pc_reset from the sequencer can release.
module program_counter_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    localparam int PTR_W      = $clog2(STACK_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_reset,
    input  logic                  jmp,
    input  logic                  rtn,
    input  logic                  flag_0,
    input  logic                  flag_f,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [LVL_W-1:0]      stack_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [LVL_W-1:0]      level_dec;
    logic [LVL_W-1:0]      level_next;
    logic                  halted_next;
    logic                  overflow_next;
    logic                  underflow_next;
    logic                  push_en;
    logic                  restart;

    assign restart   = reset | pc_reset;
    assign pc_inc    = pc + ADDR_WIDTH'(1);
    assign level_dec = stack_level - LVL_W'(1);

    // Priority below the resets: halted > flag_f > jmp > rtn > increment.
    always_comb begin
        pc_next        = pc;
        level_next     = stack_level;
        halted_next    = halted;
        overflow_next  = overflow;
        underflow_next = underflow;
        push_en        = 1'b0;
        if (halted) begin
            pc_next = pc;
        end else if (flag_f) begin
            halted_next = 1'b1;
        end else if (jmp) begin
            pc_next = jump_target;
            if (flag_0) begin
                if (stack_level < FULL_LEVEL) begin
                    push_en    = 1'b1;
                    level_next = stack_level + LVL_W'(1);
                end else begin
                    overflow_next = 1'b1;
                end
            end
        end else if (rtn) begin
            if (stack_level != '0) begin
                pc_next    = stack_mem[level_dec[PTR_W-1:0]];
                level_next = level_dec;
            end else begin
                underflow_next = 1'b1;
                pc_next        = pc_inc;
            end
        end else begin
            pc_next = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            pc          <= '0;
            halted      <= 1'b0;
            stack_level <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pc          <= pc_next;
            halted      <= halted_next;
            stack_level <= level_next;
            overflow    <= overflow_next;
            underflow   <= underflow_next;
        end
    end

    // Stack contents are not reset; the write pointer is the current level.
    always_ff @(posedge clk) begin
        if (push_en && !restart) begin
            stack_mem[stack_level[PTR_W-1:0]] <= pc_inc;
        end
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Consumer end of the reset sequencing interface. It takes `pc_reset` from the reset sequencer and the control-flow strobes `jmp`, `rtn`, `flag_0` and `flag_f` from the ICU.
- Maintains the instruction address presented to program memory.
- Holds a small hardware return stack for subroutine call/return.
- Supports halt-on-FLAGF, released only by the reset sequencer.

Parameters:
- ADDR_WIDTH, 8, width of program address and jump target.
- STACK_DEPTH, 4, number of return-stack entries (power of two, >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- pc_reset  input  1  synchronous restart request from reset sequencer, held for two clk cycles.
- jmp  input  1  ICU JMP strobe, one cycle per JMP instruction.
- rtn  input  1  ICU RTN strobe, one cycle per RTN instruction.
- flag_0  input  1  ICU FLAG0 strobe; qualifies jmp as call (JSR).
- flag_f  input  1  ICU FLAGF strobe; halt request.
- jump_target  input  ADDR_WIDTH  instruction operand address, valid with jmp.
- pc  output  ADDR_WIDTH  current program address.
- halted  output  1  PC frozen by FLAGF.
- stack_level  output  $clog2(STACK_DEPTH)+1  number of valid return entries.
- overflow  output  1  sticky: call attempted with stack full.
- underflow  output  1  sticky: return attempted with stack empty.

Behaviour:
- Clocking and reset:
  - One clock (`clk`). Reset is synchronous and active-high on `reset`; all updates occur on the rising edge of `clk`.
  - Reset values (`reset` or `pc_reset`): pc=0, halted=0, stack_level=0, overflow=0, underflow=0. Stack RAM contents are don't-care.
- Priority per edge, highest first: `reset` > `pc_reset` > `halted` > `flag_f` > `jmp` > `rtn` > increment.
- Normal step: pc <= pc+1, modulo 2^ADDR_WIDTH. 2^W-1 wraps to 0 with no flag.
- Plain jump (`jmp`=1, `flag_0`=0): pc <= jump_target; stack untouched.
- Call (`jmp`=1, `flag_0`=1):
  - pc <= jump_target.
  - If stack_level<STACK_DEPTH: push (pc+1 mod 2^W) and increment stack_level.
  - If full: no push, stack_level unchanged, overflow <= 1; jump still taken.
- Return (`rtn`=1, `jmp`=0):
  - If stack_level>0: pc <= top entry and decrement stack_level.
  - If empty: underflow <= 1 and pc <= pc+1.
- `jmp` and `rtn` in the same cycle: `jmp` wins; `rtn` is ignored entirely (no pop, no flag).
- `flag_f`=1 (not halted):
  - halted <= 1; pc holds its current value.
  - Any simultaneous `jmp` or `rtn` is ignored.
- While halted:
  - pc, stack and flags frozen; all strobes ignored.
  - Only `reset` or `pc_reset` clear the halt.
- Repeated `pc_reset` cycles: pc stays 0. The first non-reset edge afterwards increments to 1 (or applies a strobe).
- `overflow` and `underflow` stay set until `reset` or `pc_reset`.
- Latency: every output reflects the strobes registered on the preceding edge. No combinational path from inputs to outputs.
- Stack is LIFO. Push and pop share a single pointer equal to stack_level.

Test Plan:
- Reset: assert `reset` 1 cycle, then idle 5 cycles -> pc 0,1,2,3,4,5; halted=0; stack_level=0; overflow=0; underflow=0.
- Plain jump: at pc=0x10, pulse `jmp`, jump_target=0x80 -> pc=0x80 next cycle, then 0x81; stack_level stays 0.
- Call/return: at pc=0x20, `jmp`+`flag_0` target 0x50 -> pc=0x50, stack_level=1. Three steps to 0x53, then `rtn` -> pc=0x21, stack_level=0.
- Stack limits: five nested calls from pc=0x00, each target 0x10*k -> stack_level=4, overflow=1 after the fifth. Five `rtn`: the first four restore in LIFO order; the fifth sets underflow=1 and increments pc.
- Halt and release: `flag_f` at pc=0x33 -> pc holds 0x33 and halted=1 for 10 cycles, ignoring `jmp` target 0x99. `pc_reset` for 2 cycles -> pc=0, halted=0, then pc=1.
- Wrap and collisions: with pc=0xFF, idle -> pc=0x00. `jmp`+`rtn` together with target 0x40 and stack_level=1 -> pc=0x40, stack_level=1. `reset` during a call cycle -> pc=0, stack_level=0.
